// File: rtl/carregador_instrucao_pkg.sv
// carregador_instrucao_pkg: shared definitions for the program loader.
// Holds the loader state encoding, default bus widths and the instruction
// memory depth. The optional checksum stage is selected with the macro
// CARREGADOR_CHECKSUM_EN in the loader itself.
package carregador_instrucao_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int MEM_DEPTH  = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/carregador_instrucao_if.sv
// carregador_instrucao_if: byte stream handshake plus instruction memory
// write port. The byte source drives through the master modport; the loader
// sits on the slave modport, so it receives stream bytes and drives the
// memory write port.
interface carregador_instrucao_if
  import carregador_instrucao_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_data
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_data
  );

endinterface

// File: rtl/carregador_instrucao.sv
// carregador_instrucao: program loader for the writable instruction memory.
// A start pulse opens a load: the first stream byte is the payload length
// (0 meaning a full 256-byte image), the following bytes are written to
// consecutive addresses starting at BASE_ADDR, wrapping at the top of memory.
// The CPU is held in reset for the whole load and released when it completes.
// Defining CARREGADOR_CHECKSUM_EN adds a trailing checksum byte (8-bit sum of
// the payload); a mismatch raises a sticky err and keeps the CPU held.
module carregador_instrucao
  import carregador_instrucao_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  carregador_instrucao_if.slave bus,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int CNT_W = $clog2(MEM_DEPTH) + 1;

  loader_state_t     state;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] in_byte;
  logic              accept;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  assign in_byte = bus.in_data;
  assign accept  = bus.in_valid & bus.in_ready;

`ifndef CARREGADOR_CHECKSUM_EN
  assign err = 1'b0;
`endif

  // Loader sequencer: every output is a register updated from the state and the accepted byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      remaining    <= '0;
      ptr          <= '0;
      bus.in_ready <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      sum          <= '0;
      err          <= 1'b0;
`endif
    end else begin
      bus.mem_we <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_LEN;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            bus.in_ready <= 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
            err          <= 1'b0;
`endif
          end
        end
        ST_LEN: begin
          if (accept) begin
            remaining <= (in_byte == '0) ? CNT_W'(MEM_DEPTH) : CNT_W'(in_byte);
            ptr       <= ADDR_W'(BASE_ADDR);
`ifdef CARREGADOR_CHECKSUM_EN
            sum       <= '0;
`endif
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            bus.mem_we   <= 1'b1;
            bus.mem_addr <= ptr;
            bus.mem_data <= in_byte;
            ptr          <= ptr + ADDR_W'(1);
            remaining    <= remaining - CNT_W'(1);
`ifdef CARREGADOR_CHECKSUM_EN
            sum          <= sum + in_byte;
            if (remaining == CNT_W'(1)) begin
              state <= ST_CHK;
            end
`else
            if (remaining == CNT_W'(1)) begin
              state        <= ST_DONE;
              bus.in_ready <= 1'b0;
            end
`endif
          end
        end
`ifdef CARREGADOR_CHECKSUM_EN
        ST_CHK: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (in_byte == sum) begin
              state <= ST_DONE;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
        end
`endif
        ST_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          bus.in_ready <= 1'b0;
          state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/carregador_instrucao.md
Name: carregador_instrucao

Overview:
- Program loader: receives a byte stream over a valid/ready handshake and writes it into the write port of the writable instruction memory. That memory is 256 x 8-bit, with the same asynchronous read port the fetch stage uses.
- Holds the processor in reset (cpu_hold) while a load is in progress, then releases it.
- Sits between the host/serial byte source and the instruction memory; it is the writer for the memory the CPU reads.

Parameters:
- ADDR_W, 8, instruction memory address width (256 locations)
- DATA_W, 8, instruction word / stream byte width
- BASE_ADDR, 0, address of the first payload byte; later addresses wrap modulo 2^ADDR_W

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- in_data  in  DATA_W  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts in_data this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  ADDR_W  write address
- mem_data  out  DATA_W  write data
- cpu_hold  out  1  keeps CPU in reset while high
- busy  out  1  load in progress
- done  out  1  single-cycle pulse when a load completes successfully
- err  out  1  checksum mismatch, sticky (only with feature)

Behaviour:
- Reset (rst=1 at clock edge): every output is 0, state is IDLE, counters are 0. A reset mid-load aborts the load; memory keeps the bytes already written.
- All outputs are registered.
- A byte is accepted in a cycle where in_valid=1 and in_ready=1. in_ready=1 in states LEN, DATA and CHK; it is 0 otherwise.
- IDLE: start=1 -> LEN next cycle, with busy=1, cpu_hold=1 and err cleared. in_valid is ignored in IDLE.
- LEN: the accepted byte is the payload length N. N=0 means 256. Store the count, set the address pointer to BASE_ADDR, then go to DATA.
- DATA: on each accepted byte at cycle t, at t+1: mem_we=1, mem_addr=pointer, mem_data=byte. The pointer then increments, wrapping 255->0. mem_we=0 in every cycle that did not follow an accept.
- Back-to-back accepts give one write per cycle. Stalls (in_valid=0) insert no writes and do not corrupt state.
- Last data byte accepted at t: the final write occurs at t+1. Without the feature, the block enters DONE at t+1.
- DONE (one cycle): done=1, cpu_hold=0, busy=0, then IDLE.
- start while busy is ignored.
- start coinciding with rst: rst wins.
- Payload length exactly 256 with BASE_ADDR=0 writes addresses 0..255 with no wrap overlap.

Optional Feature:
- Macro: CARREGADOR_CHECKSUM_EN.
- Defined:
  - After the N-th data byte, the block enters CHK and accepts one more byte.
  - A running 8-bit sum (mod 256) of the payload bytes is compared against this byte.
  - Match: DONE as above.
  - Mismatch: err=1 (sticky until the next start), busy=0, cpu_hold stays 1, no done pulse, return to IDLE.
  - The CHK byte is never written to memory.
- Undefined: no CHK state, no sum register, err tied to 0.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, LEN, DATA, CHK, DONE)
  - ADDR_W/DATA_W defaults
  - constant MEM_DEPTH=256
- Single module; no sub-module. The checksum accumulator is a few lines under the macro.

Test Plan:
- Load N=4 bytes {0x11,0x22,0x33,0x44}, in_valid continuous -> writes addr 0..3 on consecutive cycles; done one cycle after the last mem_we; cpu_hold low from that cycle; read-back matches.
- Same load with in_valid deasserted 3 cycles between bytes -> identical writes, no spurious mem_we.
- N=0x00 with BASE_ADDR=0 -> 256 writes covering 0..255.
- BASE_ADDR=0xFE, N=3 -> writes at 0xFE, 0xFF, 0x00.
- rst asserted after 2 of 5 bytes -> outputs 0 next cycle; state IDLE; addresses 0..1 written, 2..4 untouched; a new start loads correctly.
- With CARREGADOR_CHECKSUM_EN: payload {0x01,0x02}, checksum 0x03 -> done=1. Checksum 0x04 -> err=1, cpu_hold stays 1, no done pulse.
